// File: rtl/tick_sched_pkg.sv
// Shared types for the tick scheduler: channel FSM states and channel run modes.
package tick_sched_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } chan_state_e;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/tick_sched_chan.sv
// One timer channel: counts base ticks while in RUN and raises a held event on expiry.
// Handshake: evt_o is a level that stays high from expiry until ack_i is sampled high.
module tick_sched_chan
    import tick_sched_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_i,
    input  logic             cfg_we_i,
    input  logic [CNT_W-1:0] cfg_period_i,
    input  logic             cfg_mode_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             ack_i,
    output logic             evt_o,
    output logic             overrun_o,
    output chan_state_e      state_o
);

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             evt_q, evt_d;
    logic             overrun_q, overrun_d;
    logic             expire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            period_q    <= '0;
            mode_q      <= MODE_PERIODIC;
            remaining_q <= '0;
            evt_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            mode_q      <= mode_d;
            remaining_q <= remaining_d;
            evt_q       <= evt_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        mode_d      = mode_q;
        remaining_d = remaining_q;
        evt_d       = evt_q;
        overrun_d   = overrun_q;
        expire      = 1'b0;

        if (stop_i) begin
            state_d     = ST_IDLE;
            remaining_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i && period_q != '0) begin
                        state_d     = ST_RUN;
                        remaining_d = period_q;
                    end
                end
                ST_RUN: begin
                    // A restart takes priority over a tick arriving in the same cycle.
                    if (start_i) begin
                        if (period_q == '0) begin
                            state_d     = ST_IDLE;
                            remaining_d = '0;
                        end else begin
                            remaining_d = period_q;
                        end
                    end else if (tick_i) begin
                        if (remaining_q > CNT_W'(1)) begin
                            remaining_d = remaining_q - CNT_W'(1);
                        end else begin
                            expire = 1'b1;
                            if (mode_q == MODE_ONESHOT || period_q == '0) begin
                                state_d     = ST_IDLE;
                                remaining_d = '0;
                            end else begin
                                remaining_d = period_q;
                            end
                        end
                    end
                end
            endcase
        end

        // Expiry wins over ack; overrun only when the previous event was left unacked.
        if (expire) begin
            evt_d = 1'b1;
            if (evt_q && !ack_i) begin
                overrun_d = 1'b1;
            end
        end else if (ack_i) begin
            evt_d = 1'b0;
        end

        if (cfg_we_i) begin
            period_d  = cfg_period_i;
            mode_d    = cfg_mode_i;
            overrun_d = 1'b0;
        end
    end

    assign evt_o     = evt_q;
    assign overrun_o = overrun_q;
    assign state_o   = state_q;

endmodule

// File: rtl/tick_scheduler.sv
// Shared timebase: one prescaler producing base_tick_o and NCH independent timer channels.
// Optional macro TICK_SCHED_PAUSE_EN adds pause_i, which freezes prescaler and channel counts.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter  int CLK_DIV = 20_000_000,
    parameter  int NCH     = 4,
    parameter  int CNT_W   = 8,
    localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
`ifdef TICK_SCHED_PAUSE_EN
    input  logic             pause_i,
`endif
    input  logic             cfg_we_i,
    input  logic [CH_W-1:0]  cfg_ch_i,
    input  logic [CNT_W-1:0] cfg_period_i,
    input  logic             cfg_mode_i,
    input  logic [NCH-1:0]   start_i,
    input  logic [NCH-1:0]   stop_i,
    input  logic [NCH-1:0]   ack_i,
    output logic [NCH-1:0]   evt_o,
    output logic [NCH-1:0]   active_o,
    output logic [NCH-1:0]   overrun_o,
    output logic             base_tick_o
);

    localparam int                 PRESC_W    = $clog2(CLK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               presc_run;

`ifdef TICK_SCHED_PAUSE_EN
    assign presc_run = ~pause_i;
`else
    assign presc_run = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    always_comb begin
        presc_d = presc_q;
        if (presc_run) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_W'(1);
        end
    end

    // Holding the count during pause means release resumes exactly where it stopped.
    assign base_tick_o = presc_run && (presc_q == PRESC_LAST);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic        chan_we;
        chan_state_e chan_state;

        assign chan_we = cfg_we_i && (cfg_ch_i == CH_W'(i));

        tick_sched_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .tick_i      (base_tick_o),
            .cfg_we_i    (chan_we),
            .cfg_period_i(cfg_period_i),
            .cfg_mode_i  (cfg_mode_i),
            .start_i     (start_i[i]),
            .stop_i      (stop_i[i]),
            .ack_i       (ack_i[i]),
            .evt_o       (evt_o[i]),
            .overrun_o   (overrun_o[i]),
            .state_o     (chan_state)
        );

        assign active_o[i] = (chan_state == ST_RUN);
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: expected evt rise cycles are queued per channel and
// a negedge monitor pops and compares them; level checks cover reset, overrun and active.
module tb_tick_scheduler;

    localparam int CLK_DIV = 4;
    localparam int NCH     = 4;
    localparam int CNT_W   = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pause_i = 1'b0;
    logic             cfg_we_i = 1'b0;
    logic [1:0]       cfg_ch_i = '0;
    logic [CNT_W-1:0] cfg_period_i = '0;
    logic             cfg_mode_i = 1'b0;
    logic [NCH-1:0]   start_i = '0;
    logic [NCH-1:0]   stop_i = '0;
    logic [NCH-1:0]   ack_i = '0;
    logic [NCH-1:0]   evt_o;
    logic [NCH-1:0]   active_o;
    logic [NCH-1:0]   overrun_o;
    logic             base_tick_o;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int rst_cyc = 0;

    logic [31:0]    exp_q[NCH][$];
    logic [31:0]    exp_v;
    logic [NCH-1:0] evt_prev = '0;

    tick_scheduler #(
        .CLK_DIV(CLK_DIV),
        .NCH    (NCH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef TICK_SCHED_PAUSE_EN
        .pause_i     (pause_i),
`endif
        .cfg_we_i    (cfg_we_i),
        .cfg_ch_i    (cfg_ch_i),
        .cfg_period_i(cfg_period_i),
        .cfg_mode_i  (cfg_mode_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .ack_i       (ack_i),
        .evt_o       (evt_o),
        .active_o    (active_o),
        .overrun_o   (overrun_o),
        .base_tick_o (base_tick_o)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (evt_o[i] === 1'b1 && evt_prev[i] !== 1'b1) begin
                checks++;
                if (exp_q[i].size() == 0) begin
                    errors++;
                    $display("FAIL evt_rise ch%0d: unexpected rise at cycle %0d, none expected", i, cyc);
                end else begin
                    exp_v = exp_q[i].pop_front();
                    if (exp_v != 32'(cyc)) begin
                        errors++;
                        $display("FAIL evt_rise ch%0d: rose at cycle %0d, expected cycle %0d", i, cyc, exp_v);
                    end
                end
            end
        end
        evt_prev = evt_o;
    end

    // ---------------- helpers ----------------
    function automatic bit is_tick(int t);
        return (t > rst_cyc) && (((t - rst_cyc) % CLK_DIV) == CLK_DIV - 1);
    endfunction

    // Cycle at which evt is visible for the n-th tick after a start issued in cycle c.
    function automatic int exp_rise(int c, int n);
        int t;
        t = c + 1;
        while (!is_tick(t)) t++;
        return t + CLK_DIV * (n - 1) + 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        check("rst_evt", 32'(evt_o), 32'd0);
        check("rst_active", 32'(active_o), 32'd0);
        check("rst_overrun", 32'(overrun_o), 32'd0);
        check("rst_base_tick", 32'(base_tick_o), 32'd0);
        rst = 1'b0;
        rst_cyc = cyc;
    endtask

    task automatic cfg_write(input int ch, input int p, input logic m);
        cfg_we_i     = 1'b1;
        cfg_ch_i     = 2'(ch);
        cfg_period_i = 8'(p);
        cfg_mode_i   = m;
        step();
        cfg_we_i = 1'b0;
    endtask

    task automatic pulse_start(input logic [NCH-1:0] m, output int c);
        c = cyc;
        start_i = m;
        step();
        start_i = '0;
    endtask

    task automatic pulse_stop(input logic [NCH-1:0] m);
        stop_i = m;
        step();
        stop_i = '0;
    endtask

    task automatic run_cycles(input int n, input logic [NCH-1:0] ack_mask);
        for (int k = 0; k < n; k++) begin
            ack_i = evt_o & ack_mask;
            step();
        end
        ack_i = '0;
    endtask

    // ---------------- stimulus ----------------
    int c, c2, r2;

    initial begin
        do_reset();

        // base_tick cadence after reset release
        for (int k = 0; k < 8; k++) begin
            check("base_tick", 32'(base_tick_o), 32'(is_tick(cyc)));
            step();
        end

        // periodic ch0, P=3, ack every event
        cfg_write(0, 3, 1'b0);
        pulse_start(4'b0001, c);
        exp_q[0].push_back(32'(exp_rise(c, 3)));
        exp_q[0].push_back(32'(exp_rise(c, 6)));
        exp_q[0].push_back(32'(exp_rise(c, 9)));
        check("periodic_active", 32'(active_o[0]), 32'd1);
        run_cycles(38, 4'b0001);
        check("periodic_overrun", 32'(overrun_o[0]), 32'd0);
        pulse_stop(4'b0001);
        check("periodic_stopped", 32'(active_o[0]), 32'd0);

        // one-shot ch1, P=2
        cfg_write(1, 2, 1'b1);
        pulse_start(4'b0010, c);
        exp_q[1].push_back(32'(exp_rise(c, 2)));
        run_cycles(12, 4'b0010);
        check("oneshot_active", 32'(active_o[1]), 32'd0);
        check("oneshot_evt_acked", 32'(evt_o[1]), 32'd0);
        run_cycles(80, 4'b0000);
        check("oneshot_quiet", 32'(evt_o[1]), 32'd0);

        // overrun ch2, P=1 periodic, never acked
        cfg_write(2, 1, 1'b0);
        pulse_start(4'b0100, c);
        exp_q[2].push_back(32'(exp_rise(c, 1)));
        r2 = exp_rise(c, 2);
        for (int k = 0; k < 20 && cyc < r2 - 1; k++) step();
        check("overrun_evt_first", 32'(evt_o[2]), 32'd1);
        check("overrun_before_2nd", 32'(overrun_o[2]), 32'd0);
        step();
        check("overrun_after_2nd", 32'(overrun_o[2]), 32'd1);
        for (int k = 0; k < 8 && ((cyc - rst_cyc) % CLK_DIV) != 1; k++) step();
        cfg_write(2, 1, 1'b0);
        check("overrun_cfg_clear", 32'(overrun_o[2]), 32'd0);
        step();
        check("ack_on_tick_cycle", 32'(is_tick(cyc)), 32'd1);
        ack_i = 4'b0100;
        step();
        ack_i = '0;
        check("ack_expiry_evt", 32'(evt_o[2]), 32'd1);
        check("ack_expiry_overrun", 32'(overrun_o[2]), 32'd0);
        pulse_stop(4'b0100);
        run_cycles(1, 4'b0100);
        check("ch2_evt_cleared", 32'(evt_o[2]), 32'd0);
        check("ch2_idle", 32'(active_o[2]), 32'd0);

        // start/stop and restart on ch3
        cfg_write(3, 5, 1'b0);
        start_i = 4'b1000;
        stop_i  = 4'b1000;
        step();
        start_i = '0;
        stop_i  = '0;
        check("start_stop_same", 32'(active_o[3]), 32'd0);
        cfg_write(3, 0, 1'b0);
        pulse_start(4'b1000, c);
        check("start_period0", 32'(active_o[3]), 32'd0);
        cfg_write(3, 4, 1'b0);
        pulse_start(4'b1000, c);
        run_cycles(8, 4'b0000);
        pulse_start(4'b1000, c2);
        check("restart_active", 32'(active_o[3]), 32'd1);
        exp_q[3].push_back(32'(exp_rise(c2, 4)));
        run_cycles(20, 4'b0000);
        check("prerst_evt", 32'(evt_o[3]), 32'd1);
        check("prerst_active", 32'(active_o[3]), 32'd1);

        // reset mid-run discards everything, including programmed periods
        do_reset();
        pulse_start(4'b1000, c);
        check("postrst_period0", 32'(active_o[3]), 32'd0);

`ifdef TICK_SCHED_PAUSE_EN
        // pause for 10 clk mid-period delays the expiry by exactly 10 clk
        cfg_write(0, 3, 1'b0);
        pulse_start(4'b0001, c);
        exp_q[0].push_back(32'(exp_rise(c, 3) + 10));
        step();
        pause_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check("pause_no_tick", 32'(base_tick_o), 32'd0);
            step();
        end
        pause_i = 1'b0;
        run_cycles(30, 4'b0001);
`endif

        step();
        for (int i = 0; i < NCH; i++) begin
            while (exp_q[i].size() != 0) begin
                exp_v = exp_q[i].pop_front();
                checks++;
                errors++;
                $display("FAIL evt_missing ch%0d: no rise seen, expected at cycle %0d", i, exp_v);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: time limit reached at cycle %0d, expected finish earlier", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
